// File: rtl/hazard_pkg.sv
// Shared MIPS decode constants and the in-flight window entry type for the
// RAW hazard scoreboard and its decode helper.
package hazard_pkg;

  localparam int MIPS_REG_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Opcode class prefixes (opcode[5:3]) and branch patterns.
  localparam logic [2:0] CLS_IMM   = 3'b001;
  localparam logic [2:0] CLS_LOAD  = 3'b100;
  localparam logic [2:0] CLS_STORE = 3'b101;
  localparam logic [3:0] BR_ANY    = 4'b0001;  // 0001xx: all branches read rs
  localparam logic [4:0] BR_CMP    = 5'b00010; // 00010x: beq/bne also read rt

  localparam logic [MIPS_REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [MIPS_REG_W-1:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic [MIPS_REG_W-1:0] dest;
    logic                  is_load;
  } win_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage bundle between the fetch/decode front end and the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  // Handshake: an instruction is accepted on an edge where instr_valid=1 and
  // stall_out=0 and flush=0; while stall_out=1 the front end holds instr_in.
  logic             instr_valid;
  logic [31:0]      instr_in;
  logic             flush;
  logic             stall_out;
  logic [REG_W-1:0] hazard_reg;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output instr_valid, instr_in, flush,
    input  stall_out, hazard_reg, stall_count
  );

  modport slave (
    input  instr_valid, instr_in, flush,
    output stall_out, hazard_reg, stall_count
  );
endinterface

// File: rtl/hazard_decode.sv
// Combinational MIPS register-usage decode: destination, load flag and which
// source fields are actually read.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0]           instr,
  output logic [MIPS_REG_W-1:0] dest,
  output logic                  is_load,
  output logic [MIPS_REG_W-1:0] rs,
  output logic                  rs_used,
  output logic [MIPS_REG_W-1:0] rt,
  output logic                  rt_used
);

  logic [5:0] op;
  logic       unused_low;

  assign op         = instr[31:26];
  assign unused_low = ^instr[10:0];

  always_comb begin
    dest    = REG_ZERO;
    is_load = 1'b0;
    rs      = instr[25:21];
    rt      = instr[20:16];
    rs_used = 1'b0;
    rt_used = 1'b0;

    if (op == OP_RTYPE) begin
      dest = instr[15:11];
    end else if (op[5:3] == CLS_IMM || op[5:3] == CLS_LOAD) begin
      dest = instr[20:16];
    end else if (op == OP_JAL) begin
      dest = REG_RA;
    end

    is_load = (op[5:3] == CLS_LOAD);
    rs_used = (op == OP_RTYPE) || (op[5:2] == BR_ANY) || (op[5:3] == CLS_IMM) ||
              (op[5:3] == CLS_LOAD) || (op[5:3] == CLS_STORE);
    rt_used = (op == OP_RTYPE) || (op[5:1] == BR_CMP) || (op[5:3] == CLS_STORE);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: DEPTH-entry window of in-flight destinations, same-cycle
// stall, flush and saturating stall counter. Optional macro: FORWARDING_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_scoreboard_if.slave bus
);

  logic [MIPS_REG_W-1:0] dec_dest, dec_rs, dec_rt;
  logic                  dec_is_load, dec_rs_used, dec_rt_used;

  hazard_decode u_decode (
    .instr   (bus.instr_in),
    .dest    (dec_dest),
    .is_load (dec_is_load),
    .rs      (dec_rs),
    .rs_used (dec_rs_used),
    .rt      (dec_rt),
    .rt_used (dec_rt_used)
  );

  win_entry_t       win_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic             rs_ok, rt_ok, rs_hit, rt_hit, stall;
  logic             unused_tail;

  assign rs_ok       = dec_rs_used && (dec_rs != REG_ZERO);
  assign rt_ok       = dec_rt_used && (dec_rt != REG_ZERO);
  assign unused_tail = ^win_q[DEPTH-1];

  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
`ifdef FORWARDING_EN
    // Bypass covers ALU results; only a load still in its first cycle blocks.
    rs_hit = rs_ok && win_q[0].is_load && (win_q[0].dest == dec_rs);
    rt_hit = rt_ok && win_q[0].is_load && (win_q[0].dest == dec_rt);
`else
    for (int i = 0; i < DEPTH; i++) begin
      if (rs_ok && (win_q[i].dest == dec_rs)) rs_hit = 1'b1;
      if (rt_ok && (win_q[i].dest == dec_rt)) rt_hit = 1'b1;
    end
`endif
  end

  assign stall           = bus.instr_valid && !bus.flush && !reset && (rs_hit || rt_hit);
  assign bus.stall_out   = stall;
  assign bus.hazard_reg  = !stall ? '0 : (rs_hit ? REG_W'(dec_rs) : REG_W'(dec_rt));
  assign bus.stall_count = cnt_q;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) win_q[i] <= win_q[i-1];
      // A stalled or idle cycle pushes a bubble so older producers keep draining.
      if (bus.instr_valid && !stall) begin
        win_q[0] <= '{dest: dec_dest, is_load: dec_is_load};
      end else begin
        win_q[0] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=4, CNT_W=4); honours FORWARDING_EN.
module tb_hazard_scoreboard;

  localparam int DEPTH = 4;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  localparam logic [31:0] ADDI_8   = 32'h20080005;
  localparam logic [31:0] ADD_988  = 32'h01084820;
  localparam logic [31:0] ADDI_0   = 32'h20000001;
  localparam logic [31:0] ADD_900  = 32'h00004820;
  localparam logic [31:0] JAL      = 32'h0C000010;
  localparam logic [31:0] JR_31    = 32'h03E00008;
  localparam logic [31:0] LW_8_9   = 32'h8D280000;
  localparam logic [31:0] LW_8_8   = 32'h8D080000;

`ifdef FORWARDING_EN
  localparam int ALU_STALLS  = 0;
  localparam int LOAD_STALLS = 1;
  localparam int GAP_STALLS  = 0;
`else
  localparam int ALU_STALLS  = DEPTH;
  localparam int LOAD_STALLS = DEPTH;
  localparam int GAP_STALLS  = DEPTH - 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  hazard_scoreboard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard #(.DEPTH(DEPTH), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change #1 after posedge, outputs sampled at negedge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
    bus.instr_valid = v;
    bus.instr_in    = ins;
    bus.flush       = fl;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_in    = 32'h0;
    bus.flush       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Producer then held consumer: expect n stall cycles naming reg r, then acceptance.
  task automatic run_dep(input string tag, input logic [31:0] prod, input logic [31:0] cons,
                         input int n, input logic [31:0] r);
    do_reset();
    drive(1'b1, prod, 1'b0);
    check({tag, "_prod_stall"}, 32'(bus.stall_out), 32'd0);
    tick();
    for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    while (exp_q.size() > 0) begin
      logic e;
      e = exp_q.pop_front();
      drive(1'b1, cons, 1'b0);
      check({tag, "_stall"}, 32'(bus.stall_out), 32'(e));
      check({tag, "_hreg"}, 32'(bus.hazard_reg), e ? r : 32'd0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    check({tag, "_count"}, 32'(bus.stall_count), 32'(n));
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_in    = 32'h0;
    bus.flush       = 1'b0;

    do_reset();
    drive(1'b0, 32'h0, 1'b0);
    check("rst_stall", 32'(bus.stall_out), 32'd0);
    check("rst_hreg", 32'(bus.hazard_reg), 32'd0);
    check("rst_count", 32'(bus.stall_count), 32'd0);
    drive(1'b1, ADD_988, 1'b0);
    check("rst_first_instr", 32'(bus.stall_out), 32'd0);

    run_dep("alu_raw", ADDI_8, ADD_988, ALU_STALLS, 32'd8);
    run_dep("zero_reg", ADDI_0, ADD_900, 0, 32'd0);
    run_dep("jal_jr", JAL, JR_31, ALU_STALLS, 32'd31);
    run_dep("load_use", LW_8_9, ADD_988, LOAD_STALLS, 32'd8);

    // Flush squashes the window and the flushed-cycle instruction.
    do_reset();
    drive(1'b1, LW_8_9, 1'b0);
    tick();
    drive(1'b1, ADD_988, 1'b1);
    check("flush_stall", 32'(bus.stall_out), 32'd0);
    tick();
    drive(1'b1, ADD_988, 1'b0);
    check("post_flush_stall", 32'(bus.stall_out), 32'd0);
    check("post_flush_hreg", 32'(bus.hazard_reg), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("flush_count", 32'(bus.stall_count), 32'd0);

    // An idle cycle never stalls and still ages the producer by one slot.
    do_reset();
    drive(1'b1, LW_8_9, 1'b0);
    tick();
    drive(1'b0, ADD_988, 1'b0);
    check("idle_stall", 32'(bus.stall_out), 32'd0);
    tick();
    for (int i = 0; i < GAP_STALLS; i++) begin
      drive(1'b1, ADD_988, 1'b0);
      check("gap_stall", 32'(bus.stall_out), 32'd1);
      tick();
    end
    drive(1'b1, ADD_988, 1'b0);
    check("gap_accept", 32'(bus.stall_out), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0);
    check("gap_count", 32'(bus.stall_count), 32'(GAP_STALLS));

    // Self-dependent loads keep stalling long enough to saturate the counter.
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      drive(1'b1, LW_8_8, 1'b0);
      tick();
    end
    drive(1'b1, LW_8_8, 1'b0);
    check("sat_stall", 32'(bus.stall_out), 32'd1);
    check("sat_hreg", 32'(bus.hazard_reg), 32'd8);
    check("sat_count", 32'(bus.stall_count), 32'd15);
    reset = 1'b1;
    #1;
    check("rst_mid_stall", 32'(bus.stall_out), 32'd0);
    check("rst_mid_hreg", 32'(bus.hazard_reg), 32'd0);
    tick();
    check("rst_clears_count", 32'(bus.stall_count), 32'd0);
    reset = 1'b0;
    drive(1'b1, LW_8_8, 1'b0);
    check("post_rst_first", 32'(bus.stall_out), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
